vc32_mem_arbiter: RTL
=====================

// Module: vc32_mem_arbiter
// PURPOSE
//  Shares the single byte-serial external memory sequencer between two requesters:
//  M0, the CPU load/store port, and M1, an auxiliary master such as a debug loader or DMA.
//  Sits between the requesters and the sequencer's raddr/rreq/rdone/waddr/wmask/wdata/wdone port.
//  Performs round-robin arbitration and holds the grant for a whole transaction.
//  Routes done strobes and read data back to the owning requester only.
// PARAMETERS
//  RV      16  data width in bits; must be 16
//  PV      18  physical address width; addresses are [PV-1:1]
//  M0_PRI  0   1 = M0 wins every contest (fixed priority); 0 = round-robin
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  mN_raddr   in   PV-1     read word address, master N (N=0,1)
//  mN_rreq    in   2        read byte request: 01 low byte, 10 high byte, 11 word
//  mN_rdata   out  RV       read data, valid while mN_rdone=1
//  mN_rdone   out  1        1-cycle read completion strobe
//  mN_waddr   in   PV-1     write word address
//  mN_wmask   in   2        write byte mask; nonzero = write request
//  mN_wdata   in   RV       write data
//  mN_wdone   out  1        1-cycle write completion strobe
//  s_raddr    out  PV-1     read address to the sequencer
//  s_rreq     out  2        read request to the sequencer
//  s_rdata    in   RV       read data from the sequencer
//  s_rdone    in   1        read done from the sequencer
//  s_waddr    out  PV-1     write address to the sequencer
//  s_wmask    out  2        write mask to the sequencer
//  s_wdata    out  RV       write data to the sequencer
//  s_wdone    in   1        write done from the sequencer
//  busy       out  1        transaction in flight (state != IDLE)
//  owner      out  1        master currently or most recently granted
// BEHAVIOUR
//  Reset: all outputs registered and cleared to 0. State=IDLE; last-owner pointer=1, so M0 wins first.
//  Masters hold request, address and data stable until their done strobe is sampled.
//  Masters drop the request on the same edge that samples done.
//  State machine:
//   IDLE: a master is pending when |wmask or |rreq.
//    - Winner: the pending master, if only one. If both are pending, !last when M0_PRI=0, else M0.
//    - Write beats read within a master, so one transaction kind is forwarded per grant.
//    - On grant, register the winner's signals onto s_*, set owner and last <= winner, go to WAIT.
//    - The unused request field on s_* stays 0: s_rreq=0 on a write, s_wmask=0 on a read.
//   WAIT: s_* held constant.
//    - On s_wdone or s_rdone: clear s_rreq and s_wmask.
//    - Pulse owner's mN_wdone or mN_rdone for exactly 1 cycle; capture mN_rdata <= s_rdata.
//    - Go to REL.
//    - A done whose kind does not match the forwarded request is ignored.
//   REL: done strobes return to 0; state goes to IDLE.
//    - Guarantees the sequencer sees its request low for at least 1 cycle between transactions.
//  Latency:
//   - Request seen in IDLE at cycle t -> s_* valid at t+1.
//   - s_*done at cycle d -> mN_*done at d+1 -> arbiter IDLE again at d+2.
//  The non-owner never gets a done strobe. Its mN_rdata holds its last captured value.
//  A request arriving while busy waits. No preemption, no timeout.
//  Simultaneous M0 and M1 requests in the cycle IDLE is entered follow the arbitration rule above.
//  With M0_PRI=0, back-to-back contention alternates strictly M0, M1, M0, ...
//  rst_n low mid-transaction:
//   - Returns to IDLE immediately and clears the s_* requests; no done is issued.
//   - The sequencer is reset on the same rst_n, so the abandoned transaction is simply dropped.
//  Widths pass straight through; no address arithmetic.
// TESTING
//  1 Reset, M0 word read 0x1234 -> s_rreq=11 1 cycle later; s_rdone with s_rdata=0xBEEF ->
//    m0_rdone=1 for 1 cycle with m0_rdata=0xBEEF; m1_rdone stays 0.
//  2 M0 read and M1 write (wmask=01, wdata=0x00AA) raised in the same cycle, M0_PRI=0 ->
//    M0 served first; M1's s_wmask=01 appears 2 cycles after m0_rdone.
//  3 Both masters issue 4 continuous requests each -> grant order M0,M1,M0,M1,...;
//    no master waits more than 1 transaction.
//  4 M0_PRI=1, M0 re-requests every transaction while M1 is pending -> M0 always granted; M1 waits.
//  5 One master raises wmask=11 and rreq=01 together ->
//    only the write is forwarded (s_rreq=0); the read is serviced on the next grant.
//  6 rst_n pulsed low while in WAIT -> s_rreq=s_wmask=0 asynchronously; busy=0;
//    no mN_*done; the next request is granted to M0.

Source files
------------

// File: rtl/vc32_mem_arbiter.sv
// Two-master arbiter in front of the byte-serial memory sequencer.
// Grants one whole transaction at a time and routes done strobes and read data to the owner only.
module vc32_mem_arbiter #(
  parameter int RV     = 16,
  parameter int PV     = 18,
  parameter bit M0_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PV-1:1] m0_raddr,
  input  logic [1:0]    m0_rreq,
  output logic [RV-1:0] m0_rdata,
  output logic          m0_rdone,
  input  logic [PV-1:1] m0_waddr,
  input  logic [1:0]    m0_wmask,
  input  logic [RV-1:0] m0_wdata,
  output logic          m0_wdone,
  input  logic [PV-1:1] m1_raddr,
  input  logic [1:0]    m1_rreq,
  output logic [RV-1:0] m1_rdata,
  output logic          m1_rdone,
  input  logic [PV-1:1] m1_waddr,
  input  logic [1:0]    m1_wmask,
  input  logic [RV-1:0] m1_wdata,
  output logic          m1_wdone,
  output logic [PV-1:1] s_raddr,
  output logic [1:0]    s_rreq,
  input  logic [RV-1:0] s_rdata,
  input  logic          s_rdone,
  output logic [PV-1:1] s_waddr,
  output logic [1:0]    s_wmask,
  output logic [RV-1:0] s_wdata,
  input  logic          s_wdone,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, WAIT, REL} state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic          fwd_wr, fwd_wr_nx;
  logic          owner_nx, busy_nx;
  logic [PV-1:1] s_raddr_nx, s_waddr_nx;
  logic [1:0]    s_rreq_nx, s_wmask_nx;
  logic [RV-1:0] s_wdata_nx;
  logic [RV-1:0] m0_rdata_nx, m1_rdata_nx;
  logic          m0_rdone_nx, m0_wdone_nx, m1_rdone_nx, m1_wdone_nx;

  logic          pend0, pend1, win;
  logic [PV-1:1] w_raddr, w_waddr;
  logic [1:0]    w_rreq, w_wmask;
  logic [RV-1:0] w_wdata;
  logic          done_hit;

  assign pend0 = (|m0_wmask) | (|m0_rreq);
  assign pend1 = (|m1_wmask) | (|m1_rreq);

  // On contention the pointer alternates unless M0 is configured to always win.
  always_comb begin
    win = 1'b0;
    if (pend0 && pend1) begin
      win = M0_PRI ? 1'b0 : ~last;
    end else if (pend1) begin
      win = 1'b1;
    end
  end

  assign w_raddr  = win ? m1_raddr : m0_raddr;
  assign w_rreq   = win ? m1_rreq  : m0_rreq;
  assign w_waddr  = win ? m1_waddr : m0_waddr;
  assign w_wmask  = win ? m1_wmask : m0_wmask;
  assign w_wdata  = win ? m1_wdata : m0_wdata;
  assign done_hit = fwd_wr ? s_wdone : s_rdone;

  always_comb begin
    state_nx    = state;
    last_nx     = last;
    fwd_wr_nx   = fwd_wr;
    owner_nx    = owner;
    s_raddr_nx  = s_raddr;
    s_rreq_nx   = s_rreq;
    s_waddr_nx  = s_waddr;
    s_wmask_nx  = s_wmask;
    s_wdata_nx  = s_wdata;
    m0_rdata_nx = m0_rdata;
    m1_rdata_nx = m1_rdata;
    m0_rdone_nx = 1'b0;
    m0_wdone_nx = 1'b0;
    m1_rdone_nx = 1'b0;
    m1_wdone_nx = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_nx = WAIT;
          owner_nx = win;
          last_nx  = win;
          // A write outranks a read from the same master; the read waits for the next grant.
          if (|w_wmask) begin
            fwd_wr_nx  = 1'b1;
            s_waddr_nx = w_waddr;
            s_wmask_nx = w_wmask;
            s_wdata_nx = w_wdata;
            s_rreq_nx  = 2'b00;
          end else begin
            fwd_wr_nx  = 1'b0;
            s_raddr_nx = w_raddr;
            s_rreq_nx  = w_rreq;
            s_wmask_nx = 2'b00;
          end
        end
      end
      WAIT: begin
        if (done_hit) begin
          state_nx   = REL;
          s_rreq_nx  = 2'b00;
          s_wmask_nx = 2'b00;
          if (fwd_wr) begin
            m0_wdone_nx = ~owner;
            m1_wdone_nx = owner;
          end else begin
            m0_rdone_nx = ~owner;
            m1_rdone_nx = owner;
            if (owner) begin
              m1_rdata_nx = s_rdata;
            end else begin
              m0_rdata_nx = s_rdata;
            end
          end
        end
      end
      REL: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Pointer resets to M1 so that M0 takes the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      fwd_wr   <= 1'b0;
      owner    <= 1'b0;
      busy     <= 1'b0;
      s_raddr  <= '0;
      s_rreq   <= '0;
      s_waddr  <= '0;
      s_wmask  <= '0;
      s_wdata  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_rdone <= 1'b0;
      m0_wdone <= 1'b0;
      m1_rdone <= 1'b0;
      m1_wdone <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      fwd_wr   <= fwd_wr_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      s_raddr  <= s_raddr_nx;
      s_rreq   <= s_rreq_nx;
      s_waddr  <= s_waddr_nx;
      s_wmask  <= s_wmask_nx;
      s_wdata  <= s_wdata_nx;
      m0_rdata <= m0_rdata_nx;
      m1_rdata <= m1_rdata_nx;
      m0_rdone <= m0_rdone_nx;
      m0_wdone <= m0_wdone_nx;
      m1_rdone <= m1_rdone_nx;
      m1_wdone <= m1_wdone_nx;
    end
  end

endmodule
